// File: rtl/reduce_gate_pipe.sv
// rtl/reduce_gate_pipe.sv - masked N-bit logic reduction, two-stage valid/ready pipeline
// Optional transaction counter on acc_count is enabled by defining REDUCE_STATS_EN.
module reduce_gate_pipe #(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [N-1:0]     in_mask,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_err
`ifdef REDUCE_STATS_EN
  ,
  output logic [CNT_W-1:0] acc_count
`endif
);

  localparam int PW = $clog2(N + 1);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_MAJ  = 3'd6;

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + PW'(v[i]);
    end
    return acc;
  endfunction

  logic          r_s1_valid;
  logic [N-1:0]  r_s1_data;
  logic [N-1:0]  r_s1_mask;
  logic [2:0]    r_s1_op;
  logic          r_s2_valid;
  logic          r_y;
  logic          r_err;

  logic          w_adv1;
  logic          w_adv2;
  logic [N-1:0]  w_active;
  logic          w_and;
  logic          w_or;
  logic          w_xor;
  logic [PW-1:0] w_pc_ones;
  logic [PW-1:0] w_pc_mask;
  logic          w_maj;
  logic          w_y_next;
  logic          w_err_next;

  // A stage may load when it is empty or when the stage ahead is draining.
  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  // Masked-off bits become the identity: 1 for the AND family, 0 for OR/XOR.
  assign w_active  = r_s1_data & r_s1_mask;
  assign w_and     = &(r_s1_data | ~r_s1_mask);
  assign w_or      = |w_active;
  assign w_xor     = ^w_active;
  assign w_pc_ones = popcnt(w_active);
  assign w_pc_mask = popcnt(r_s1_mask);
  assign w_maj     = {w_pc_ones, 1'b0} > {1'b0, w_pc_mask};

  always_comb begin
    w_y_next   = 1'b0;
    w_err_next = 1'b0;
    case (r_s1_op)
      OP_AND:  w_y_next = w_and;
      OP_OR:   w_y_next = w_or;
      OP_XOR:  w_y_next = w_xor;
      OP_NAND: w_y_next = !w_and;
      OP_NOR:  w_y_next = !w_or;
      OP_XNOR: w_y_next = !w_xor;
      OP_MAJ:  w_y_next = w_maj;
      default: w_err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mask  <= '0;
      r_s1_op    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_mask <= in_mask;
        r_s1_op   <= in_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_y        <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y   <= w_y_next;
        r_err <= w_err_next;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_y     = r_y;
  assign out_err   = r_err;

`ifdef REDUCE_STATS_EN
  logic [CNT_W-1:0] r_acc_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_count <= '0;
    end else if (in_valid && w_adv1) begin
      r_acc_count <= r_acc_count + CNT_W'(1);
    end
  end

  assign acc_count = r_acc_count;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb/tb_reduce_gate_pipe.sv - directed self-checking bench for reduce_gate_pipe
// Instance a: N=3, CNT_W=16. Instance b: N=4, CNT_W=2.
module tb_reduce_gate_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_y, a_out_err;
  logic [2:0] a_in_data, a_in_mask, a_in_op;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_y, b_out_err;
  logic [3:0] b_in_data, b_in_mask;
  logic [2:0] b_in_op;
`ifdef REDUCE_STATS_EN
  logic [15:0] a_acc;
  logic [1:0]  b_acc;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reduce_gate_pipe #(.N(3), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mask(a_in_mask), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_y(a_out_y), .out_err(a_out_err)
`ifdef REDUCE_STATS_EN
    , .acc_count(a_acc)
`endif
  );

  reduce_gate_pipe #(.N(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mask(b_in_mask), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_y(b_out_y), .out_err(b_out_err)
`ifdef REDUCE_STATS_EN
    , .acc_count(b_acc)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [2:0] d, input logic [2:0] m, input logic [2:0] op,
                       output logic y, output logic err, output logic got);
    a_in_data = d; a_in_mask = m; a_in_op = op; a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int c = 0; c < 10 && !a_in_ready; c++) step();
    step();
    a_in_valid = 1'b0;
    got = 1'b0; y = 1'b0; err = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (a_out_valid) begin
        y = a_out_y; err = a_out_err; got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic run_b(input logic [3:0] d, input logic [3:0] m, input logic [2:0] op,
                       output logic y, output logic err, output logic got);
    b_in_data = d; b_in_mask = m; b_in_op = op; b_out_ready = 1'b1; b_in_valid = 1'b1;
    for (int c = 0; c < 10 && !b_in_ready; c++) step();
    step();
    b_in_valid = 1'b0;
    got = 1'b0; y = 1'b0; err = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (b_out_valid) begin
        y = b_out_y; err = b_out_err; got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_in_mask = 0; a_in_op = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = 0; b_in_mask = 0; b_in_op = 0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if ({a_out_valid, a_out_y, a_out_err} !== 3'b000)
      $display("FAIL reset_a_outputs got=%b exp=000", {a_out_valid, a_out_y, a_out_err}); else n_pass++;
    n_total++; if ({b_out_valid, b_out_y, b_out_err} !== 3'b000)
      $display("FAIL reset_b_outputs got=%b exp=000", {b_out_valid, b_out_y, b_out_err}); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); else n_pass++;
`ifdef REDUCE_STATS_EN
    n_total++; if (a_acc !== 16'd0) $display("FAIL reset_acc_count got=%0d exp=0", a_acc); else n_pass++;
`endif
  endtask

  task automatic test_or_sweep;
    a_in_mask = 3'b111; a_in_op = 3'd1; a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_valid = (i < 8);
      a_in_data  = 3'(i);
      step();
      if (i >= 1 && i <= 8) begin
        n_total++; if ({a_out_valid, a_out_y, a_out_err} !== {1'b1, (i - 1) != 0, 1'b0})
          $display("FAIL or_sweep_item%0d got=%b exp=%b", i - 1, {a_out_valid, a_out_y, a_out_err},
                   {1'b1, (i - 1) != 0, 1'b0});
        else n_pass++;
      end else if (i == 9) begin
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL or_sweep_tail_valid got=%b exp=0", a_out_valid);
        else n_pass++;
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_ops;
    logic [2:0] ops[7] = '{3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 3'd6, 3'd6};
    logic [2:0] dat[7] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b001};
    logic       exp[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic y, err, got;
    for (int i = 0; i < 7; i++) begin
      run_a(dat[i], 3'b111, ops[i], y, err, got);
      n_total++; if ({got, y, err} !== {1'b1, exp[i], 1'b0})
        $display("FAIL ops_op%0d_d%b got(v,y,err)=%b exp=%b", ops[i], dat[i], {got, y, err}, {1'b1, exp[i], 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_mask;
    logic [3:0] dat[10] = '{4'b1100, 4'b1100, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0101};
    logic [3:0] msk[10] = '{4'b1100, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    logic [2:0] ops[10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
    logic       exp[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic y, err, got;
    for (int i = 0; i < 10; i++) begin
      run_b(dat[i], msk[i], ops[i], y, err, got);
      n_total++; if ({got, y, err} !== {1'b1, exp[i], 1'b0})
        $display("FAIL mask_n4_op%0d_d%b_m%b got(v,y,err)=%b exp=%b", ops[i], dat[i], msk[i],
                 {got, y, err}, {1'b1, exp[i], 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] d[4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic       e[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic res[$];
    int   idx = 0;
    a_in_mask = 3'b111; a_in_op = 3'd2; a_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_in_valid = (idx < 4);
      a_in_data  = d[idx < 4 ? idx : 0];
      #1;
      if (c >= 2) begin
        n_total++; if ({a_out_valid, a_out_y} !== {1'b1, e[0]})
          $display("FAIL bp_hold_c%0d got(v,y)=%b exp=%b", c, {a_out_valid, a_out_y}, {1'b1, e[0]});
        else n_pass++;
      end
      if (a_in_valid && a_in_ready) idx++;
      step();
    end
    n_total++; if (idx !== 2) $display("FAIL bp_accepts got=%0d exp=2", idx); else n_pass++;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready_low got=%b exp=0", a_in_ready); else n_pass++;
    a_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a_in_valid = (idx < 4);
      a_in_data  = d[idx < 4 ? idx : 0];
      #1;
      if (c == 0) begin
        n_total++; if (a_in_ready !== 1'b1)
          $display("FAIL bp_same_cycle_accept got=%b exp=1", a_in_ready); else n_pass++;
      end
      if (a_in_valid && a_in_ready) idx++;
      if (a_out_valid) res.push_back(a_out_y);
      step();
    end
    a_in_valid = 1'b0;
    n_total++; if (res.size() !== 4) $display("FAIL bp_result_count got=%0d exp=4", res.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (i >= res.size() || res[i] !== e[i])
        $display("FAIL bp_order_item%0d got=%b exp=%b", i, (i < res.size()) ? res[i] : 1'bx, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reserved_op;
    logic y, err, got;
    run_a(3'b101, 3'b111, 3'd7, y, err, got);
    n_total++; if ({got, y, err} !== 3'b101) $display("FAIL reserved_op got(v,y,err)=%b exp=101", {got, y, err});
    else n_pass++;
    run_a(3'b010, 3'b111, 3'd1, y, err, got);
    n_total++; if ({got, y, err} !== 3'b110) $display("FAIL after_reserved_or got(v,y,err)=%b exp=110", {got, y, err});
    else n_pass++;
  endtask

  task automatic test_reset_midop;
    logic seen;
    a_out_ready = 1'b1; a_in_mask = 3'b111; a_in_op = 3'd1; a_in_data = 3'b111; a_in_valid = 1'b1;
    step();
    step();
    a_in_valid = 1'b0;
    n_total++; if ({a_out_valid, a_out_y} !== 2'b11)
      $display("FAIL midop_pre_reset got(v,y)=%b exp=11", {a_out_valid, a_out_y}); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({a_out_valid, a_out_y} !== 2'b00)
      $display("FAIL midop_async_clear got(v,y)=%b exp=00", {a_out_valid, a_out_y}); else n_pass++;
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (a_out_valid) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL midop_stale_output got=%b exp=0", seen); else n_pass++;
`ifdef REDUCE_STATS_EN
    n_total++; if (a_acc !== 16'd0) $display("FAIL midop_acc_cleared got=%0d exp=0", a_acc); else n_pass++;
`endif
  endtask

`ifdef REDUCE_STATS_EN
  task automatic test_stats;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_in_mask = 3'b111; a_in_op = 3'd0; a_in_data = 3'b000;
    b_in_mask = 4'b1111; b_in_op = 3'd0; b_in_data = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      a_in_valid = (c < 3);
      b_in_valid = 1'b1;
      step();
      if (c == 3) begin
        n_total++; if (b_acc !== 2'd0) $display("FAIL stats_b_wrap_to0 got=%0d exp=0", b_acc); else n_pass++;
      end
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    n_total++; if (a_acc !== 16'd3) $display("FAIL stats_a_count got=%0d exp=3", a_acc); else n_pass++;
    n_total++; if (b_acc !== 2'd1) $display("FAIL stats_b_wrap got=%0d exp=1", b_acc); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_or_sweep();
    test_ops();
    test_mask();
    test_back_to_back();
    test_reserved_op();
    test_reset_midop();
`ifdef REDUCE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
